// File: rtl/even_parity_rx_if.sv
// Serial-in / word-out bundle for the even-parity receiver.
// err_count is present only when EVEN_PARITY_RX_ERRCNT_EN is defined.
interface even_parity_rx_if #(
    parameter int unsigned DATA_W = 3
);
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef EVEN_PARITY_RX_ERRCNT_EN
    logic [7:0]        err_count;

    modport master (
        output bit_en, rx,
        input  data_out, data_valid, parity_err, frame_err, busy, err_count
    );
    modport slave (
        input  bit_en, rx,
        output data_out, data_valid, parity_err, frame_err, busy, err_count
    );
`else
    modport master (
        output bit_en, rx,
        input  data_out, data_valid, parity_err, frame_err, busy
    );
    modport slave (
        input  bit_en, rx,
        output data_out, data_valid, parity_err, frame_err, busy
    );
`endif
endinterface

// File: rtl/even_parity_rx.sv
// Even-parity serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating parity-error counter enabled by EVEN_PARITY_RX_ERRCNT_EN.
module even_parity_rx #(
    parameter int unsigned DATA_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    even_parity_rx_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;  // parity verdict held until the stop bit
    logic              valid_q, valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        par_d        = par_q;
        perr_d       = perr_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (bus.bit_en) begin
            case (state_q)
                StIdle: begin
                    if (!bus.rx) begin
                        state_d = StData;
                        idx_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                StData: begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (idx_q == IdxW'(i)) shift_d[i] = bus.rx;
                    end
                    par_d = par_q ^ bus.rx;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(DATA_W - 1)) state_d = StParity;
                end
                StParity: begin
                    perr_d  = par_q ^ bus.rx;
                    state_d = StStop;
                end
                StStop: begin
                    data_d       = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = !bus.rx;
                    valid_d      = 1'b1;
                    state_d      = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != StIdle);

`ifdef EVEN_PARITY_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (valid_d && parity_err_d && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_even_parity_rx.sv
// Scoreboard bench for even_parity_rx: frames queue their expected word and flags,
// a negedge monitor pops and compares on every data_valid.
module tb_even_parity_rx;
    localparam int unsigned DATA_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    even_parity_rx_if #(.DATA_W(DATA_W)) rx_bus ();

    even_parity_rx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rx_bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (rx_bus.data_valid === 1'b1) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: data_valid high %0d consecutive cycles, required 1", 2);
            end
            checks++;
            got = {rx_bus.data_out, rx_bus.parity_err, rx_bus.frame_err};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got {data,perr,ferr}=%h, no frame expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL frame_result: got {data,perr,ferr}=%h, required %h", got, e);
                end
            end
        end
        prev_valid = (rx_bus.data_valid === 1'b1);
    end

    task automatic drive_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            rx_bus.bit_en = 1'b0;
            rx_bus.rx     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rx_bus.bit_en = 1'b1;
        rx_bus.rx     = b;
        @(posedge clk);
        #1;
        rx_bus.bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input logic stop, input int gap);
        exp_t e;
        e.data = data;
        e.perr = (^data) ^ par;
        e.ferr = ~stop;
        exp_q.push_back(e);
        drive_bit(1'b0, gap);
        checks++;
        if (rx_bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b after start bit, required 1", rx_bus.busy);
        end
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i], gap);
        drive_bit(par, gap);
        drive_bit(stop, gap);
        checks++;
        if (rx_bus.data_valid !== 1'b1 || rx_bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL valid_latency: data_valid=%b busy=%b after stop, required 1/0",
                     rx_bus.data_valid, rx_bus.busy);
        end
        rx_bus.rx = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rx_bus.bit_en = 1'b0;
        rx_bus.rx     = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_bus.data_out, rx_bus.data_valid, rx_bus.parity_err, rx_bus.frame_err,
             rx_bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b perr=%b ferr=%b busy=%b, required 0",
                     rx_bus.data_out, rx_bus.data_valid, rx_bus.parity_err,
                     rx_bus.frame_err, rx_bus.busy);
        end
`ifdef EVEN_PARITY_RX_ERRCNT_EN
        checks++;
        if (rx_bus.err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_errcnt: err_count=%0d, required 0", rx_bus.err_count);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_frame(3'b101, 1'b0, 1'b1, 0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        send_frame(3'b111, 1'b1, 1'b1, 0);
        send_frame(3'b110, 1'b1, 1'b1, 0);
        wait_drain();
`ifdef EVEN_PARITY_RX_ERRCNT_EN
        checks++;
        if (rx_bus.err_count !== 8'd1) begin
            errors++;
            $display("FAIL errcnt_b2b: err_count=%0d, required 1", rx_bus.err_count);
        end
`endif
    endtask

    task automatic test_frame_err();
        send_frame(3'b011, 1'b0, 1'b0, 0);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rx_bus.data_out !== 3'd3 || rx_bus.frame_err !== 1'b1 ||
            rx_bus.parity_err !== 1'b0 || rx_bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_ferr: data=%h ferr=%b perr=%b busy=%b, required 3/1/0/0",
                     rx_bus.data_out, rx_bus.frame_err, rx_bus.parity_err, rx_bus.busy);
        end
    endtask

    task automatic test_sparse();
        send_frame(3'b101, 1'b0, 1'b1, 3);
        send_frame(3'b100, 1'b0, 1'b1, 3);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_bus.data_out, rx_bus.data_valid, rx_bus.parity_err, rx_bus.frame_err,
             rx_bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: data=%h valid=%b perr=%b ferr=%b busy=%b, required 0",
                     rx_bus.data_out, rx_bus.data_valid, rx_bus.parity_err,
                     rx_bus.frame_err, rx_bus.busy);
        end
        rst_n     = 1'b1;
        rx_bus.rx = 1'b1;
        @(posedge clk);
        #1;
        send_frame(3'b010, 1'b1, 1'b1, 0);
        wait_drain();
        checks++;
        if (rx_bus.data_out !== 3'b010) begin
            errors++;
            $display("FAIL after_reset_frame: data_out=%h, required 2", rx_bus.data_out);
        end
    endtask

`ifdef EVEN_PARITY_RX_ERRCNT_EN
    task automatic test_errcnt_sat();
        for (int n = 0; n < 260; n++) begin
            send_frame(3'b000, 1'b1, 1'b1, 0);
            wait_drain();
        end
        checks++;
        if (rx_bus.err_count !== 8'd255) begin
            errors++;
            $display("FAIL errcnt_sat: err_count=%0d, required 255", rx_bus.err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_sparse();
        test_reset_mid();
`ifdef EVEN_PARITY_RX_ERRCNT_EN
        test_errcnt_sat();
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
